// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: BCD digit geometry, display modes and the
// button press qualifier constants used by the core and the lap stage.
package stopwatch_pkg;

    localparam int BCD_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = BCD_DIGITS * DIGIT_W;

    // Two low samples followed by two high samples qualify one press.
    localparam logic [3:0] PRESS_PATTERN = 4'b0011;
    // All-ones start value forces two low samples before the first press.
    localparam logic [3:0] BTN_SR_RESET  = 4'hF;

    typedef enum logic {
        LIVE = 1'b0,
        LAP  = 1'b1
    } mode_e;

    function automatic logic is_press(input logic [3:0] sr);
        return (sr == PRESS_PATTERN);
    endfunction

endpackage

// File: rtl/button_press.sv
// Raw button qualifier: 4-sample shift register, one-cycle press event when
// the history matches low-low-high-high. A held button yields one event.
module button_press
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic [3:0] sr_reg;

    // Shift in the raw button level; reset discards any press in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_reg <= BTN_SR_RESET;
        end else begin
            sr_reg <= {sr_reg[2:0], btn};
        end
    end

    assign press = is_press(sr_reg);

endmodule

// File: rtl/lap_recall.sv
// Lap memory and display select: captures the live BCD time into a circular
// buffer on lap presses and shows either the live time or a chosen lap.
module lap_recall
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BCD_W-1:0] live_bcd,
    input  logic             lap_btn,
    input  logic             view_btn,
    input  logic             clr_btn,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             disp_is_lap,
    output logic [IDX_W-1:0] lap_age,
    output logic [CNT_W-1:0] lap_count
);

    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT  = '0;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Button qualifiers, bit 0 = lap, bit 1 = view, bit 2 = clear.
    logic [2:0] btn_vec;
    logic [2:0] press_vec;
    logic       lap_ev;
    logic       view_ev;
    logic       clr_ev;

    assign btn_vec = {clr_btn, view_btn, lap_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            button_press u_press (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (btn_vec[gi]),
                .press (press_vec[gi])
            );
        end
    endgenerate

    assign lap_ev  = press_vec[0];
    assign view_ev = press_vec[1];
    assign clr_ev  = press_vec[2];

    // Control state.
    mode_e            mode_reg,   mode_next;
    logic [IDX_W-1:0] age_reg,    age_next;
    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic [CNT_W-1:0] count_post;
    logic             mem_we;

    // Lap storage; contents survive reset and clear, validity is tracked by count.
    logic [BCD_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_slot;
    logic [BCD_W-1:0] rd_data;

    // Display output stage.
    logic [BCD_W-1:0] disp_bcd_reg;
    logic             disp_is_lap_reg;
    logic [IDX_W-1:0] lap_age_reg;

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg   <= LIVE;
            age_reg    <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            mode_reg   <= mode_next;
            age_reg    <= age_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Next-state: clear wins; otherwise capture first, then view decides on
    // the post-capture count so a same-cycle lap+view from empty enters LAP.
    always_comb begin
        mode_next   = mode_reg;
        age_next    = age_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        count_post  = count_reg;
        mem_we      = 1'b0;

        if (clr_ev) begin
            mode_next   = LIVE;
            age_next    = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (lap_ev) begin
                mem_we      = 1'b1;
                wr_ptr_next = wr_ptr_reg + ONE_IDX;
                if (count_reg != DEPTH_CNT) begin
                    count_post = count_reg + ONE_CNT;
                end
            end
            count_next = count_post;

            if (view_ev) begin
                case (mode_reg)
                    LIVE: begin
                        if (count_post != ZERO_CNT) begin
                            mode_next = LAP;
                            age_next  = '0;
                        end
                    end
                    LAP: begin
                        // Age is relative to the newest lap, so a capture in
                        // LAP keeps the age and the view shifts to newer data.
                        if (CNT_W'(age_reg) < (count_post - ONE_CNT)) begin
                            age_next = age_reg + ONE_IDX;
                        end else begin
                            mode_next = LIVE;
                            age_next  = '0;
                        end
                    end
                    default: begin
                        mode_next = LIVE;
                        age_next  = '0;
                    end
                endcase
            end
        end
    end

    // Lap capture write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= live_bcd;
        end
    end

    // Newest lap sits just behind the write pointer; wraps naturally.
    assign rd_slot = wr_ptr_reg - ONE_IDX - age_reg;
    assign rd_data = mem[rd_slot];

    // Registered display select feeding the seven-segment converters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_bcd_reg    <= '0;
            disp_is_lap_reg <= 1'b0;
            lap_age_reg     <= '0;
        end else begin
            disp_bcd_reg    <= (mode_reg == LAP) ? rd_data : live_bcd;
            disp_is_lap_reg <= (mode_reg == LAP);
            lap_age_reg     <= (mode_reg == LAP) ? age_reg : '0;
        end
    end

    assign disp_bcd    = disp_bcd_reg;
    assign disp_is_lap = disp_is_lap_reg;
    assign lap_age     = lap_age_reg;
    assign lap_count   = count_reg;

endmodule

// File: tb/tb_lap_recall.sv
// Self-checking bench for lap_recall: directed scenarios plus randomized
// button combinations against a queue-based model of the lap list.
module tb_lap_recall;

    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [23:0]      live_bcd = '0;
    logic             lap_btn = 1'b0;
    logic             view_btn = 1'b0;
    logic             clr_btn = 1'b0;
    logic [23:0]      disp_bcd;
    logic             disp_is_lap;
    logic [IDX_W-1:0] lap_age;
    logic [CNT_W-1:0] lap_count;

    lap_recall #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .live_bcd    (live_bcd),
        .lap_btn     (lap_btn),
        .view_btn    (view_btn),
        .clr_btn     (clr_btn),
        .disp_bcd    (disp_bcd),
        .disp_is_lap (disp_is_lap),
        .lap_age     (lap_age),
        .lap_count   (lap_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: list of stored laps, newest first, plus view mode and age.
    logic [23:0] m_laps[$];
    bit          m_lap_mode = 1'b0;
    int          m_age = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int d = 0; d < 6; d++) begin
            v[d*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_laps.delete();
        m_lap_mode = 1'b0;
        m_age = 0;
    endtask

    task automatic model_event(input bit l, input bit v, input bit c);
        if (c) begin
            model_reset();
        end else begin
            if (l) begin
                m_laps.push_front(live_bcd);
                if (m_laps.size() > DEPTH) void'(m_laps.pop_back());
            end
            if (v) begin
                if (!m_lap_mode) begin
                    if (m_laps.size() > 0) begin
                        m_lap_mode = 1'b1;
                        m_age = 0;
                    end
                end else if (m_age < m_laps.size() - 1) begin
                    m_age++;
                end else begin
                    m_lap_mode = 1'b0;
                    m_age = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [23:0] e;
        e = m_lap_mode ? m_laps[m_age] : live_bcd;
        check({tag, ".disp"},  32'(disp_bcd),    32'(e));
        check({tag, ".islap"}, 32'(disp_is_lap), 32'(m_lap_mode));
        check({tag, ".age"},   32'(lap_age),     32'(m_lap_mode ? m_age : 0));
        check({tag, ".count"}, 32'(lap_count),   32'(m_laps.size()));
    endtask

    // Live digits must appear exactly one clock later, not combinationally.
    task automatic live_probe(input string tag);
        logic [23:0] a;
        logic [23:0] e;
        @(negedge clk);
        a = rand_bcd();
        live_bcd = a;
        @(posedge clk);
        #1 live_bcd = rand_bcd();
        @(negedge clk);
        e = m_lap_mode ? m_laps[m_age] : a;
        check({tag, ".live_delay"}, 32'(disp_bcd), 32'(e));
    endtask

    // Release, let the qualifier see low samples, hold, release, settle.
    task automatic press(input bit l, input bit v, input bit c, input int hold);
        @(negedge clk);
        lap_btn = 1'b0; view_btn = 1'b0; clr_btn = 1'b0;
        repeat (3) @(negedge clk);
        lap_btn = l; view_btn = v; clr_btn = c;
        repeat (hold) @(negedge clk);
        lap_btn = 1'b0; view_btn = 1'b0; clr_btn = 1'b0;
        repeat (4) @(negedge clk);
        model_event(l, v, c);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.disp",  32'(disp_bcd),    32'h0);
        check("reset.islap", 32'(disp_is_lap), 32'h0);
        check("reset.age",   32'(lap_age),     32'h0);
        check("reset.count", 32'(lap_count),   32'h0);
        rst_n = 1'b1;

        // Live passthrough
        live_bcd = 24'h012345;
        @(negedge clk);
        check("live.disp",  32'(disp_bcd),    32'h012345);
        check("live.islap", 32'(disp_is_lap), 32'h0);
        check("live.count", 32'(lap_count),   32'h0);

        // First lap with latency checks on the count
        live_bcd = 24'h000110;
        repeat (3) @(negedge clk);
        lap_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat.count_t1", 32'(lap_count), 32'h0);
        lap_btn = 1'b0;
        @(negedge clk);
        check("lat.count_t2", 32'(lap_count), 32'h1);
        repeat (3) @(negedge clk);
        model_event(1'b1, 1'b0, 1'b0);

        live_bcd = 24'h000220;
        press(1'b1, 1'b0, 1'b0, 2);
        live_bcd = 24'h012345;

        // View with display latency checks
        repeat (3) @(negedge clk);
        view_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        view_btn = 1'b0;
        @(negedge clk);
        check("lat.islap_t2", 32'(disp_is_lap), 32'h0);
        @(negedge clk);
        check("lat.islap_t3", 32'(disp_is_lap), 32'h1);
        check("lat.disp_t3",  32'(disp_bcd),    32'h000220);
        model_event(1'b0, 1'b1, 1'b0);
        check_all("two.v1");
        press(1'b0, 1'b1, 1'b0, 2);
        check("two.v2.disp", 32'(disp_bcd), 32'h000110);
        check("two.v2.age",  32'(lap_age),  32'h1);
        check_all("two.v2");
        press(1'b0, 1'b1, 1'b0, 2);
        check("two.v3.islap", 32'(disp_is_lap), 32'h0);
        check_all("two.v3");

        // Overwrite: five laps into four slots
        press(1'b0, 1'b0, 1'b1, 2);
        for (int i = 1; i <= 5; i++) begin
            live_bcd = 24'(i);
            press(1'b1, 1'b0, 1'b0, 2);
        end
        live_bcd = 24'h999999;
        check("wrap.count", 32'(lap_count), 32'h4);
        for (int k = 0; k < 4; k++) begin
            press(1'b0, 1'b1, 1'b0, 3);
            check($sformatf("wrap.view%0d.disp", k), 32'(disp_bcd), 32'(5 - k));
            check_all($sformatf("wrap.view%0d", k));
        end
        press(1'b0, 1'b1, 1'b0, 2);
        check_all("wrap.back_live");

        // View with no laps, then a long hold yields one event
        press(1'b0, 1'b0, 1'b1, 2);
        press(1'b0, 1'b1, 1'b0, 2);
        check_all("empty.view");
        live_bcd = 24'h000001; press(1'b1, 1'b0, 1'b0, 2);
        live_bcd = 24'h000002; press(1'b1, 1'b0, 1'b0, 2);
        press(1'b0, 1'b1, 1'b0, 100);
        check("hold.age", 32'(lap_age), 32'h0);
        check_all("hold");

        // Simultaneous presses
        press(1'b1, 1'b1, 1'b1, 2);
        check_all("sim.all3");
        live_bcd = 24'h543210;
        press(1'b1, 1'b1, 1'b0, 2);
        check("sim.lv.disp", 32'(disp_bcd), 32'h543210);
        check_all("sim.lap_view");

        // Reset while in LAP with three laps
        live_bcd = 24'h111111; press(1'b1, 1'b0, 1'b0, 2);
        live_bcd = 24'h222222; press(1'b1, 1'b0, 1'b0, 2);
        check_all("rst.pre");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst.disp",  32'(disp_bcd),    32'h0);
        check("rst.islap", 32'(disp_is_lap), 32'h0);
        check("rst.age",   32'(lap_age),     32'h0);
        check("rst.count", 32'(lap_count),   32'h0);
        model_reset();
        press(1'b0, 1'b1, 1'b0, 2);
        check_all("rst.view");

        // Reset in the middle of a held lap press discards it
        repeat (3) @(negedge clk);
        lap_btn = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        lap_btn = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        check_all("rst.midpress");

        // Randomized button combinations
        for (int n = 0; n < 40; n++) begin
            bit l, v, c;
            int hold;
            l = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(2, 6);
            @(negedge clk);
            live_bcd = rand_bcd();
            press(l, v, c, hold);
            check_all($sformatf("rnd%0d", n));
            live_probe($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lap_recall.md
# lap_recall

Lap-memory and display-select stage between the stopwatch time counter and the six seven-segment converters. It consumes the live six-digit BCD time and stores up to DEPTH lap snapshots in a circular buffer. It drives the six BCD digits that the converters render: either the live time or a stored lap chosen with the view button. All button handling uses the same 4-sample press qualifier as the stopwatch core.

## Interface
- DEPTH, 4, number of stored laps; power of two, minimum 2
- IDX_W, $clog2(DEPTH), width of slot/age indices
- CNT_W, $clog2(DEPTH+1), width of lap_count
- clk  in  1  system clock; every register uses its rising edge
- rst_n  in  1  reset, synchronous, active-low
- live_bcd  in  24  live time, digit5..digit0 as [23:20]..[3:0]; each digit 0-9
- lap_btn  in  1  raw lap/capture button, active-high
- view_btn  in  1  raw view-cycle button, active-high
- clr_btn  in  1  raw clear-laps button, active-high
- disp_bcd  out  24  digits to the seven-segment converters, registered
- disp_is_lap  out  1  1 when disp_bcd shows a stored lap
- lap_age  out  IDX_W  age of the displayed lap; 0 = newest; 0 in LIVE
- lap_count  out  CNT_W  number of valid stored laps, 0..DEPTH

## Operation
- Each button feeds a 4-bit shift register, {sr[2:0], btn}, that resets to 4'hF. A press event is asserted while sr == 4'b0011. A held button produces exactly one event.
- Modes: LIVE and LAP. Reset enters LIVE.
- lap event: writes live_bcd into mem[wr_ptr] and sets wr_ptr = wr_ptr+1 (mod DEPTH). lap_count saturates at DEPTH. When the buffer is full, the oldest entry is overwritten.
- view event, LIVE, lap_count == 0: stays in LIVE.
- view event, LIVE, lap_count > 0: enters LAP with age = 0.
- view event, LAP, age < lap_count-1: age = age+1.
- view event, LAP, age == lap_count-1: returns to LIVE with age = 0.
- Displayed slot in LAP: (wr_ptr - 1 - age) mod DEPTH.
- Age is relative. A lap captured while in LAP keeps the same age, so the display moves to the newer content.
- clr event: lap_count = 0, wr_ptr = 0, mode LIVE, age = 0. Memory contents are left as they are and are never shown again.
- Simultaneous events, same cycle:
  - clr overrides lap and view.
  - lap and view both apply. The view decision uses the post-capture lap_count.
- The block does no BCD arithmetic. Digits pass through unchanged.

## Timing
- Reset, on the first edge with rst_n = 0:
  - all sr registers = 4'hF, mode LIVE, age 0, wr_ptr 0, lap_count 0.
  - disp_bcd 0, disp_is_lap 0, lap_age 0.
  - The memory array is not reset.
- Press latency:
  - btn high at edges t and t+1 after two low samples gives sr == 0011 after edge t+1.
  - Mode, pointer and count registers update at edge t+2.
  - disp_bcd, disp_is_lap and lap_age update at edge t+3.
- lap_count updates at the same edge as the capture.
- LIVE mode: disp_bcd = live_bcd delayed by exactly one clock.
- Reset asserted mid-press: the press is discarded. sr = 4'hF requires two low samples before the next press can qualify.

## Structure
- Shared package stopwatch_pkg holds:
  - BCD_DIGITS = 6 and DIGIT_W = 4
  - the mode enum (LIVE, LAP)
  - PRESS_PATTERN = 4'b0011 and BTN_SR_RESET = 4'hF
- Sub-module button_press: shift register plus pattern compare, instantiated three times. The stopwatch core reuses it.
- Memory is a register array of DEPTH x 24 bits with an asynchronous read and a registered output stage.

## Test plan
- Reset, then hold live_bcd = 24'h012345 -> disp_bcd = 24'h012345 one clock later. disp_is_lap 0, lap_count 0.
- Laps at 24'h000110, 24'h000220, then view -> disp_bcd 24'h000220, lap_age 0. View -> 24'h000110, lap_age 1. View -> LIVE.
- Five laps with values 1..5 in digit0 and DEPTH = 4 -> lap_count 4. View cycles 5, 4, 3, 2, then LIVE. Value 1 is overwritten.
- View with lap_count 0 -> stays LIVE, disp_is_lap 0. Button held high for 100 cycles -> exactly one event.
- lap, view and clr pressed on the same cycle -> lap_count 0, LIVE, no capture. lap and view on the same cycle from LIVE with 0 laps -> lap_count 1, LAP, age 0.
- rst_n low for 1 cycle while in LAP with 3 laps -> all outputs 0, LIVE. A following view press does not enter LAP.
